// File: rtl/sonar_pkg.sv
// Shared types and helpers for the multi-channel sonar scan controller.
//   scan_state_t : scan FSM state encoding (IDLE, FIRE, WAIT, HOLD)
//   DEF_MAX_MM   : default distance reported for a failed/invalid channel
//   therm()      : thermometer code with 'lit' low bits set, capped at n
package sonar_pkg;

    localparam int unsigned DEF_MAX_MM = 4095;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t IDLE = 2'd0;
    localparam scan_state_t FIRE = 2'd1;
    localparam scan_state_t WAIT = 2'd2;
    localparam scan_state_t HOLD = 2'd3;

    // Returns (1 << min(lit, n)) - 1 without a variable shift.
    function automatic logic [31:0] therm(input int unsigned lit, input int unsigned n);
        logic [31:0] t;
        t = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            t[i] = (i < lit) && (i < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/sonar_ema.sv
// Shared EMA datapath and per-channel filter state for the sonar scan controller.
// Only the channel addressed by 'ch' is updated in a given cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   store      : one-cycle strobe, fold 'sample' into channel 'ch'
//   fail       : one-cycle strobe, invalidate channel 'ch'
//   ch         : channel being updated
//   sample     : raw distance in mm (clamped to MAX_MM here)
//   dist_flat  : registered filtered distance per channel, ch0 in LSBs
//   ch_valid   : registered per-channel "last slot succeeded" flags
module sonar_ema import sonar_pkg::*; #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DIST_W   = 12,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned MAX_MM   = DEF_MAX_MM,
    parameter int unsigned CH_W     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     store,
    input  logic                     fail,
    input  logic [CH_W-1:0]          ch,
    input  logic [DIST_W-1:0]        sample,
    output logic [NUM_CH*DIST_W-1:0] dist_flat,
    output logic [NUM_CH-1:0]        ch_valid
);

    localparam int unsigned AW = DIST_W + AVG_LOG2;

    logic [AW-1:0]     acc [NUM_CH];
    logic [AW-1:0]     acc_cur;
    logic              cur_vld;
    logic [DIST_W-1:0] sample_cl;
    logic [AW-1:0]     acc_upd;
    logic [DIST_W-1:0] dist_new;

    // Select the addressed channel's history.
    always_comb begin
        acc_cur = '0;
        cur_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) begin
                acc_cur = acc[i];
                cur_vld = ch_valid[i];
            end
        end
    end

    // Seed on first success, otherwise acc += sample - acc/2^AVG_LOG2.
    // The sum stays within AW bits because acc never exceeds MAX_MM << AVG_LOG2.
    always_comb begin
        sample_cl = (sample > DIST_W'(MAX_MM)) ? DIST_W'(MAX_MM) : sample;
        if (cur_vld) begin
            acc_upd = acc_cur + AW'(sample_cl) - (acc_cur >> AVG_LOG2);
        end else begin
            acc_upd = AW'(sample_cl) << AVG_LOG2;
        end
        dist_new = DIST_W'(acc_upd >> AVG_LOG2);
    end

    // Per-channel filter state and published distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            dist_flat <= '0;
            ch_valid  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ch == CH_W'(i)) begin
                    if (store) begin
                        acc[i]                       <= acc_upd;
                        dist_flat[i*DIST_W +: DIST_W] <= dist_new;
                        ch_valid[i]                  <= 1'b1;
                    end else if (fail) begin
                        acc[i]                       <= '0;
                        dist_flat[i*DIST_W +: DIST_W] <= DIST_W'(MAX_MM);
                        ch_valid[i]                  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sonar_scan_ctrl.sv
// Round-robin multi-channel ultrasonic scan controller. Drives one shared
// ranging engine through a channel mux, applies a per-slot timeout and
// per-channel EMA filtering, and publishes the nearest target and an LED bar.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : run scanning (a dropped enable finishes the current slot)
//   rng_ready   : ranging engine idle
//   rng_valid   : one-cycle pulse, rng_dist valid
//   rng_dist    : measured distance, mm
//   rng_start   : one-cycle start pulse to the engine
//   ch_sel      : channel routed to the engine, changes only between slots
//   dist_flat   : filtered distance per channel, ch0 in LSBs
//   ch_valid    : channel's most recent slot succeeded
//   nearest_ch  : index of the smallest valid distance (lowest index on ties)
//   nearest_mm  : smallest valid distance, MAX_MM when none valid
//   nearest_vld : at least one channel valid
//   bar         : thermometer LED bar, LSB-aligned
module sonar_scan_ctrl import sonar_pkg::*; #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIST_W      = 12,
    parameter int unsigned PERIOD_CYC  = 5_000_000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned BAR_LEDS    = 10,
    parameter int unsigned BAR_STEP_MM = 100,
    parameter int unsigned MAX_MM      = DEF_MAX_MM,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     rng_ready,
    input  logic                     rng_valid,
    input  logic [DIST_W-1:0]        rng_dist,
    output logic                     rng_start,
    output logic [CH_W-1:0]          ch_sel,
    output logic [NUM_CH*DIST_W-1:0] dist_flat,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [CH_W-1:0]          nearest_ch,
    output logic [DIST_W-1:0]        nearest_mm,
    output logic                     nearest_vld,
    output logic [BAR_LEDS-1:0]      bar
);

    localparam int unsigned     TMR_W  = $clog2(PERIOD_CYC);
    localparam logic [TMR_W-1:0] LAST_T = TMR_W'(PERIOD_CYC - 1);
    localparam logic [TMR_W-1:0] TOUT_T = TMR_W'(TIMEOUT_CYC);

    scan_state_t      state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [TMR_W-1:0] start_time, start_time_n;
    logic [CH_W-1:0]  ch_sel_n;
    logic             rng_start_n;
    logic             store_c;
    logic             fail_c;

    // Scan FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            start_time <= '0;
            ch_sel     <= '0;
            rng_start  <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            start_time <= start_time_n;
            ch_sel     <= ch_sel_n;
            rng_start  <= rng_start_n;
        end
    end

    // Scan FSM next state, start pulse and store/fail strobes.
    always_comb begin
        state_n      = state;
        timer_n      = timer;
        start_time_n = start_time;
        ch_sel_n     = ch_sel;
        rng_start_n  = 1'b0;
        store_c      = 1'b0;
        fail_c       = 1'b0;

        case (state)
            IDLE: begin
                timer_n = '0;
                if (enable) begin
                    state_n = FIRE;
                end
            end
            FIRE: begin
                timer_n = timer + TMR_W'(1);
                if (rng_ready) begin
                    rng_start_n  = 1'b1;
                    start_time_n = timer;
                    state_n      = WAIT;
                end else if (timer == TOUT_T) begin
                    fail_c  = 1'b1;
                    state_n = HOLD;
                end
            end
            WAIT: begin
                timer_n = timer + TMR_W'(1);
                // A late start could push the timeout past the slot end; the
                // slot end then acts as the timeout so the period never stretches.
                if (rng_valid) begin
                    store_c = 1'b1;
                    state_n = HOLD;
                end else if ((timer - start_time) == TOUT_T || timer == LAST_T) begin
                    fail_c  = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                timer_n = timer + TMR_W'(1);
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Slot boundary: the channel advances even when stopping, so a restart
        // continues the rotation.
        if (state != IDLE && timer == LAST_T) begin
            timer_n  = '0;
            ch_sel_n = (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + CH_W'(1);
            state_n  = enable ? FIRE : IDLE;
        end
    end

    sonar_ema #(
        .NUM_CH   (NUM_CH),
        .DIST_W   (DIST_W),
        .AVG_LOG2 (AVG_LOG2),
        .MAX_MM   (MAX_MM),
        .CH_W     (CH_W)
    ) u_ema (
        .clk       (clk),
        .rst_n     (rst_n),
        .store     (store_c),
        .fail      (fail_c),
        .ch        (ch_sel),
        .sample    (rng_dist),
        .dist_flat (dist_flat),
        .ch_valid  (ch_valid)
    );

    logic                near_vld_c;
    logic [DIST_W-1:0]   near_mm_c;
    logic [CH_W-1:0]     near_ch_c;
    logic [BAR_LEDS-1:0] closer_c;
    logic [31:0]         lit_c;
    logic [BAR_LEDS-1:0] bar_c;

    // Min-reduce over valid channels; strict '<' keeps the lowest index on ties.
    always_comb begin
        near_vld_c = 1'b0;
        near_mm_c  = DIST_W'(MAX_MM);
        near_ch_c  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i] && (!near_vld_c || dist_flat[i*DIST_W +: DIST_W] < near_mm_c)) begin
                near_vld_c = 1'b1;
                near_mm_c  = dist_flat[i*DIST_W +: DIST_W];
                near_ch_c  = CH_W'(i);
            end
        end
    end

    // Number of lit LEDs = count of step thresholds k*BAR_STEP_MM (k=1..BAR_LEDS)
    // strictly above the distance, which equals BAR_LEDS - mm/BAR_STEP_MM clamped at 0.
    for (genvar k = 0; k < BAR_LEDS; k++) begin : g_bar_cmp
        assign closer_c[k] = (32'(near_mm_c) < 32'((k + 1) * BAR_STEP_MM));
    end

    always_comb begin
        lit_c = '0;
        for (int unsigned i = 0; i < BAR_LEDS; i++) begin
            lit_c = lit_c + 32'(closer_c[i]);
        end
        bar_c = near_vld_c ? BAR_LEDS'(therm(lit_c, BAR_LEDS)) : '0;
    end

    // Nearest-target and LED bar output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nearest_vld <= 1'b0;
            nearest_mm  <= DIST_W'(MAX_MM);
            nearest_ch  <= '0;
            bar         <= '0;
        end else begin
            nearest_vld <= near_vld_c;
            nearest_mm  <= near_mm_c;
            nearest_ch  <= near_ch_c;
            bar         <= bar_c;
        end
    end

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Self-checking bench for sonar_scan_ctrl: directed scenarios followed by
// randomized slots, checked against a behavioural model of the scan rules.
module tb_sonar_scan_ctrl;

    localparam int NUM_CH  = 2;
    localparam int DIST_W  = 12;
    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 60;
    localparam int AVG_L2  = 1;
    localparam int BAR_N   = 10;
    localparam int STEP_MM = 100;
    localparam int MAX_MM  = 4095;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic                     rng_ready;
    logic                     rng_valid;
    logic [DIST_W-1:0]        rng_dist;
    logic                     rng_start;
    logic [0:0]               ch_sel;
    logic [NUM_CH*DIST_W-1:0] dist_flat;
    logic [NUM_CH-1:0]        ch_valid;
    logic [0:0]               nearest_ch;
    logic [DIST_W-1:0]        nearest_mm;
    logic                     nearest_vld;
    logic [BAR_N-1:0]         bar;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_acc  [NUM_CH];
    int exp_dist [NUM_CH];
    bit exp_vld  [NUM_CH];
    int exp_ch;
    int prev_start;
    int cnt;

    sonar_scan_ctrl #(
        .NUM_CH      (NUM_CH),
        .DIST_W      (DIST_W),
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TIMEOUT),
        .AVG_LOG2    (AVG_L2),
        .BAR_LEDS    (BAR_N),
        .BAR_STEP_MM (STEP_MM),
        .MAX_MM      (MAX_MM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rng_ready   (rng_ready),
        .rng_valid   (rng_valid),
        .rng_dist    (rng_dist),
        .rng_start   (rng_start),
        .ch_sel      (ch_sel),
        .dist_flat   (dist_flat),
        .ch_valid    (ch_valid),
        .nearest_ch  (nearest_ch),
        .nearest_mm  (nearest_mm),
        .nearest_vld (nearest_vld),
        .bar         (bar)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            exp_acc[i] = 0; exp_dist[i] = 0; exp_vld[i] = 1'b0;
        end
    endtask

    task automatic model_store(input int c, input int s);
        int d;
        d = (s > MAX_MM) ? MAX_MM : s;
        if (!exp_vld[c]) exp_acc[c] = d * (2 ** AVG_L2);
        else             exp_acc[c] = exp_acc[c] + d - exp_acc[c] / (2 ** AVG_L2);
        exp_dist[c] = exp_acc[c] / (2 ** AVG_L2);
        exp_vld[c]  = 1'b1;
    endtask

    task automatic model_fail(input int c);
        exp_acc[c] = 0; exp_dist[c] = MAX_MM; exp_vld[c] = 1'b0;
    endtask

    task automatic check_dist();
        logic [NUM_CH*DIST_W-1:0] f;
        logic [NUM_CH-1:0]        v;
        for (int i = 0; i < NUM_CH; i++) begin
            f[i*DIST_W +: DIST_W] = DIST_W'(exp_dist[i]);
            v[i] = exp_vld[i];
        end
        chk("dist_flat", dist_flat, f);
        chk("ch_valid", ch_valid, v);
    endtask

    task automatic check_near();
        int best, mm, q, lit;
        logic [BAR_N-1:0] eb;
        best = -1;
        for (int i = 0; i < NUM_CH; i++)
            if (exp_vld[i] && (best < 0 || exp_dist[i] < exp_dist[best])) best = i;
        mm  = (best < 0) ? MAX_MM : exp_dist[best];
        q   = mm / STEP_MM;
        lit = (q >= BAR_N) ? 0 : BAR_N - q;
        eb  = (best < 0) ? '0 : BAR_N'((1 << lit) - 1);
        chk("nearest_vld", nearest_vld, (best >= 0));
        chk("nearest_ch", nearest_ch, (best < 0) ? 0 : best);
        chk("nearest_mm", nearest_mm, mm);
        chk("bar", bar, eb);
    endtask

    task automatic check_reset();
        chk("rst_rng_start", rng_start, 0);
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_dist_flat", dist_flat, 0);
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_nearest_vld", nearest_vld, 0);
        chk("rst_nearest_mm", nearest_mm, MAX_MM);
        chk("rst_nearest_ch", nearest_ch, 0);
        chk("rst_bar", bar, 0);
    endtask

    task automatic count_starts(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rng_start === 1'b1) c++;
        end
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (rng_start === 1'b1) got = 1'b1;
        end
        chk("start_seen", got, 1);
    endtask

    // One slot: wait for the start pulse, optionally answer 'dly' cycles later,
    // check the result, then poke a stray rng_valid during HOLD.
    task automatic do_slot(input bit answer, input int dly, input int sample, input bit drop_en);
        bit got;
        int k, c;
        wait_start(got);
        if (!got) return;
        c = exp_ch;
        chk("ch_sel", ch_sel, c);
        if (prev_start >= 0) chk("start_spacing", cyc - prev_start, PERIOD);
        prev_start = cyc;
        tick(); k = 1;
        chk("start_width", rng_start, 0);
        if (drop_en) enable = 1'b0;
        if (answer) begin
            while (k < dly) begin tick(); k++; end
            rng_valid = 1'b1; rng_dist = DIST_W'(sample);
            tick(); k++;
            rng_valid = 1'b0; rng_dist = DIST_W'($urandom);
            model_store(c, sample);
        end else begin
            while (k < TIMEOUT - 1) begin tick(); k++; end
            chk("pre_timeout_valid", ch_valid[c], exp_vld[c]);
            tick(); k++;
            model_fail(c);
        end
        check_dist();
        tick(); k++;
        check_near();
        while (k < 80) begin tick(); k++; end
        rng_valid = 1'b1; rng_dist = DIST_W'($urandom);
        tick();
        rng_valid = 1'b0;
        check_dist();
        exp_ch = (c + 1) % NUM_CH;
    endtask

    // Engine never ready for a whole slot: FIRE times out, no start issued.
    task automatic ready_low_slot();
        int c;
        rng_ready = 1'b0;
        count_starts(PERIOD, cnt);
        chk("ready_low_no_start", cnt, 0);
        c = exp_ch;
        model_fail(c);
        check_dist();
        check_near();
        exp_ch = (c + 1) % NUM_CH;
        prev_start = prev_start + PERIOD;
        rng_ready = 1'b1;
    endtask

    task automatic reset_mid_wait();
        bit got;
        wait_start(got);
        if (!got) return;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        model_reset();
        exp_ch = 0;
        prev_start = -1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; rng_ready = 1'b1; rng_valid = 1'b0; rng_dist = '0;
        model_reset();
        exp_ch = 0; prev_start = -1;

        // 1: reset, released with enable low
        repeat (5) tick();
        check_reset();
        rst_n = 1'b1;
        tick();
        check_reset();
        count_starts(150, cnt);
        chk("idle_no_start", cnt, 0);

        // 2: seed both channels with 500
        enable = 1'b1;
        do_slot(1, 20, 500, 0);
        chk("dist0_seed", dist_flat[11:0], 500);
        chk("valid_01", ch_valid, 2'b01);
        do_slot(1, 20, 500, 0);
        chk("valid_11", ch_valid, 2'b11);
        chk("bar_500", bar, 10'b0000011111);

        // 3: EMA updates on ch0
        do_slot(1, 20, 300, 0);
        chk("dist0_ema_300", dist_flat[11:0], 400);
        do_slot(1, 20, 500, 0);
        do_slot(1, 20, 400, 0);
        chk("dist0_ema_400", dist_flat[11:0], 400);

        // 4: ch1 timeout, then re-seed
        do_slot(0, 0, 0, 0);
        chk("ch1_fail_valid", ch_valid[1], 0);
        chk("ch1_fail_dist", dist_flat[23:12], MAX_MM);
        do_slot(1, 20, 400, 0);
        do_slot(1, 20, 200, 0);
        chk("ch1_reseed", dist_flat[23:12], 200);

        // 5: tie resolves to ch0, then ch1 becomes nearest at 150
        do_slot(0, 0, 0, 0);
        do_slot(0, 0, 0, 0);
        do_slot(1, 20, 700, 0);
        do_slot(1, 20, 700, 0);
        chk("tie_lowest_ch", nearest_ch, 0);
        do_slot(1, 20, 700, 0);
        do_slot(0, 0, 0, 0);
        do_slot(1, 20, 700, 0);
        do_slot(1, 20, 150, 0);
        chk("near_ch1", nearest_ch, 1);
        chk("near_mm_150", nearest_mm, 150);
        chk("bar_150", bar, 10'b0111111111);

        // engine busy for a whole slot
        ready_low_slot();

        // 6: valid coincident with timeout cycle is stored
        do_slot(1, TIMEOUT - 1, 321, 0);
        chk("coincident_stored", dist_flat[23:12], exp_dist[1]);

        // reset asserted during WAIT
        reset_mid_wait();

        // randomized slots
        for (int i = 0; i < 40; i++) begin
            int s;
            s = $urandom_range(0, 1) ? $urandom_range(0, 1100) : $urandom_range(0, MAX_MM);
            do_slot($urandom_range(0, 9) != 0, $urandom_range(2, TIMEOUT - 1), s, 0);
        end

        // enable dropped mid-slot: slot completes, then scanning stops
        do_slot(1, 30, 250, 1);
        count_starts(250, cnt);
        chk("drop_en_idle", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
